// File: rtl/pc_lut_ctrl.sv
// Program-counter sequencer with a writable jump table (relative/absolute entries).
// Define PC_LUT_INIT_EN to preload a fixed set of relative offsets at reset.
module pc_lut_ctrl #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic [PTR_W-1:0] ptr,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PC_W-1:0]  wr_data,
  input  logic             wr_abs,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;

  // Entry layout: {abs mode bit, value}
  logic [PC_W:0]   tbl_q [DEPTH];

`ifdef PC_LUT_INIT_EN
  function automatic logic [PC_W:0] init_entry(int unsigned idx);
    logic [PC_W-1:0] v;
    case (idx)
      1:       v = PC_W'(-11);
      2:       v = PC_W'(7);
      3:       v = PC_W'(-18);
      4:       v = PC_W'(11);
      5:       v = PC_W'(2);
      6:       v = PC_W'(15);
      default: v = '0;
    endcase
    return {1'b0, v};
  endfunction
`else
  function automatic logic [PC_W:0] init_entry(int unsigned idx);
    return (idx < DEPTH) ? '0 : '0;
  endfunction
`endif

  // Table write; Branch reads tbl_q combinationally so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl_q[i] <= init_entry(i);
    end else if (wr_en) begin
      tbl_q[wr_ptr] <= {wr_abs, wr_data};
    end
  end

  logic [PC_W:0]   entry;
  logic            ent_abs;
  logic [PC_W-1:0] ent_val;
  logic [PC_W+1:0] rel_sum;
  logic [PC_W:0]   inc_sum;

  assign entry   = tbl_q[ptr];
  assign ent_abs = entry[PC_W];
  assign ent_val = entry[PC_W-1:0];
  // Two guard bits: top bits 11 means the true sum went negative, 01 means it overflowed.
  assign rel_sum = {2'b00, pc_q} + {{2{ent_val[PC_W-1]}}, ent_val};
  assign inc_sum = {1'b0, pc_q} + (PC_W+1)'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          pc_d    = start_pc;
        end
      end
      StRun: begin
        if (halt) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch) begin
          if (ent_abs) begin
            pc_d = ent_val;
          end else begin
            pc_d   = rel_sum[PC_W-1:0];
            wrap_d = |rel_sum[PC_W+1:PC_W];
          end
        end else begin
          pc_d   = inc_sum[PC_W-1:0];
          wrap_d = inc_sum[PC_W];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == StRun);
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_pc_lut_ctrl.sv
// Directed self-checking bench for pc_lut_ctrl (PC_W=8, DEPTH=32); follows PC_LUT_INIT_EN.
module tb_pc_lut_ctrl;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic [PC_W-1:0]  start_pc = '0;
  logic             stall = 1'b0;
  logic             halt = 1'b0;
  logic             branch = 1'b0;
  logic [PTR_W-1:0] ptr = '0;
  logic             wr_en = 1'b0;
  logic [PTR_W-1:0] wr_ptr = '0;
  logic [PC_W-1:0]  wr_data = '0;
  logic             wr_abs = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic             wrap;

  int errors = 0;
  int checks = 0;

  pc_lut_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .start_pc (start_pc),
    .stall    (stall),
    .halt     (halt),
    .branch   (branch),
    .ptr      (ptr),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .wr_data  (wr_data),
    .wr_abs   (wr_abs),
    .pc       (pc),
    .running  (running),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Reset-time relative offset of table entry k.
  function automatic int init_off(int k);
`ifdef PC_LUT_INIT_EN
    case (k)
      1: return -11;
      2: return 7;
      3: return -18;
      4: return 11;
      5: return 2;
      6: return 15;
      default: return 0;
    endcase
`else
    return (k < 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int k, input logic [7:0] val, input logic abs_mode);
    wr_en = 1'b1; wr_ptr = PTR_W'(k); wr_data = val; wr_abs = abs_mode;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic begin_run(input logic [7:0] spc);
    start = 1'b1; start_pc = spc;
    tick();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || pc !== spc) begin
      errors++;
      $display("FAIL start: running=%b pc=%0h expected running=1 pc=%0h", running, pc, spc);
    end
  endtask

  task automatic end_run();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00 || running !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%0h run=%b done=%b wrap=%b expected all 0", pc, running, done, wrap);
    end
    @(negedge clk);
    reset_n = 1'b1;
    branch = 1'b1; stall = 1'b1;
    tick();
    branch = 1'b0; stall = 1'b0;
    checks++;
    if (pc !== 8'h00 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: pc=%0h run=%b expected pc=0 run=0", pc, running);
    end
  endtask

  task automatic test_init_table();
    for (int k = 0; k < 10; k++) begin
      logic [7:0] exp_pc;
      exp_pc = 8'(100 + init_off(k));
      begin_run(8'd100);
      branch = 1'b1; ptr = PTR_W'(k);
      tick();
      branch = 1'b0;
      checks++;
      if (pc !== exp_pc || wrap !== 1'b0) begin
        errors++;
        $display("FAIL init_entry%0d: pc=%0h wrap=%b expected pc=%0h wrap=0", k, pc, wrap, exp_pc);
      end
      end_run();
    end
  endtask

  task automatic test_branch_rel();
`ifndef PC_LUT_INIT_EN
    write_entry(1, 8'hF5, 1'b0);
`endif
    begin_run(8'd20);
    branch = 1'b1; ptr = 5'd1;
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'd9) begin
      errors++;
      $display("FAIL rel_branch: pc=%0d expected 9", pc);
    end
    tick();
    checks++;
    if (pc !== 8'd10) begin
      errors++;
      $display("FAIL rel_incr: pc=%0d expected 10", pc);
    end
    end_run();
  endtask

  task automatic test_branch_abs();
    write_entry(5, 8'h40, 1'b1);
    begin_run(8'h10);
    branch = 1'b1; ptr = 5'd5;
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'h40 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL abs_branch: pc=%0h wrap=%b expected pc=40 wrap=0", pc, wrap);
    end
    end_run();
    begin_run(8'hF0);
    branch = 1'b1; ptr = 5'd5;
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'h40 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL abs_nowrap: pc=%0h wrap=%b expected pc=40 wrap=0", pc, wrap);
    end
    end_run();
  endtask

  task automatic test_wrap();
    begin_run(8'hFF);
    tick();
    checks++;
    if (pc !== 8'h00 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL incr_wrap: pc=%0h wrap=%b expected pc=0 wrap=1", pc, wrap);
    end
    tick();
    checks++;
    if (pc !== 8'h01 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear: pc=%0h wrap=%b expected pc=1 wrap=0", pc, wrap);
    end
    end_run();
    write_entry(7, 8'h10, 1'b0);
    write_entry(8, 8'hF0, 1'b0);
    begin_run(8'hF8);
    branch = 1'b1; ptr = 5'd7;
    tick();
    checks++;
    if (pc !== 8'h08 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL rel_wrap_up: pc=%0h wrap=%b expected pc=08 wrap=1", pc, wrap);
    end
    ptr = 5'd8;
    tick();
    checks++;
    if (pc !== 8'hF8 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL rel_wrap_down: pc=%0h wrap=%b expected pc=f8 wrap=1", pc, wrap);
    end
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'hE8 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL rel_neg_nowrap: pc=%0h wrap=%b expected pc=e8 wrap=0", pc, wrap);
    end
    end_run();
  endtask

  task automatic test_priority();
    begin_run(8'd12);
    stall = 1'b1; branch = 1'b1; ptr = 5'd7;
    tick();
    checks++;
    if (pc !== 8'd12 || running !== 1'b1) begin
      errors++;
      $display("FAIL stall: pc=%0d run=%b expected pc=12 run=1", pc, running);
    end
    start = 1'b1; start_pc = 8'd99; stall = 1'b0; branch = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (pc !== 8'd13) begin
      errors++;
      $display("FAIL start_in_run: pc=%0d expected 13", pc);
    end
    end_run();
    begin_run(8'd12);
    halt = 1'b1; stall = 1'b1; branch = 1'b1; ptr = 5'd7;
    tick();
    halt = 1'b0; stall = 1'b0;
    checks++;
    if (pc !== 8'd12 || running !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL halt_prio: pc=%0d run=%b done=%b expected pc=12 run=0 done=1",
               pc, running, done);
    end
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'd12 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: pc=%0d run=%b done=%b expected pc=12 run=0 done=0",
               pc, running, done);
    end
  endtask

  task automatic test_write_collide();
`ifndef PC_LUT_INIT_EN
    write_entry(3, 8'hEE, 1'b0);
`endif
    begin_run(8'd30);
    branch = 1'b1; ptr = 5'd3;
    wr_en = 1'b1; wr_ptr = 5'd3; wr_data = 8'd4; wr_abs = 1'b0;
    tick();
    wr_en = 1'b0;
    checks++;
    if (pc !== 8'd12) begin
      errors++;
      $display("FAIL collide_old: pc=%0d expected 12", pc);
    end
    tick();
    branch = 1'b0;
    checks++;
    if (pc !== 8'd16) begin
      errors++;
      $display("FAIL collide_new: pc=%0d expected 16", pc);
    end
    end_run();
  endtask

  task automatic test_async_reset();
    begin_run(8'h37);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00 || running !== 1'b0 || wrap !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: pc=%0h run=%b expected pc=0 run=0", pc, running);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 3; k <= 5; k += 2) begin
      logic [7:0] exp_pc;
      exp_pc = 8'(100 + init_off(k));
      begin_run(8'd100);
      branch = 1'b1; ptr = PTR_W'(k);
      tick();
      branch = 1'b0;
      checks++;
      if (pc !== exp_pc) begin
        errors++;
        $display("FAIL restored_entry%0d: pc=%0h expected %0h", k, pc, exp_pc);
      end
      end_run();
    end
  endtask

  initial begin
    test_reset();
    test_init_table();
    test_branch_rel();
    test_branch_abs();
    test_wrap();
    test_priority();
    test_write_collide();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_lut_ctrl.md
PC_LUT_CTRL -- requirements
Module: pc_lut_ctrl

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program counter and offset width in bits.
REQ-002 Parameter DEPTH, default 32, SHALL set the jump-table entry count; PTR_W = $clog2(DEPTH).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Start  input  1  SHALL be a pulse that begins execution at Start_pc.
REQ-006 Start_pc  input  PC_W  SHALL be the first PC of a run.
REQ-007 Stall  input  1  SHALL hold PC for the cycle.
REQ-008 Halt  input  1  SHALL end the run.
REQ-009 Branch  input  1  SHALL request a table-driven PC change this cycle.
REQ-010 Ptr  input  PTR_W  SHALL select the table entry used by Branch.
REQ-011 Wr_en  input  1  SHALL write one table entry.
REQ-012 Wr_ptr  input  PTR_W  SHALL be the entry written.
REQ-013 Wr_data  input  PC_W  SHALL be the entry value: signed offset or absolute target.
REQ-014 Wr_abs  input  1  SHALL store the entry mode: 1 absolute, 0 relative.
REQ-015 PC  output  PC_W  SHALL be the registered program counter.
REQ-016 Running  output  1  SHALL be high in state RUN.
REQ-017 Done  output  1  SHALL pulse for one cycle on the RUN->DONE transition.
REQ-018 Wrap  output  1  SHALL be a registered flag, high for one cycle after any PC update that wrapped modulo 2^PC_W.

Function
REQ-019 Table SHALL hold DEPTH entries of {mode bit, PC_W value}; read combinationally by Ptr, written synchronously.
REQ-020 Write and Branch reading the same entry in the same cycle SHALL use the pre-write contents.
REQ-021 Writes SHALL be accepted in every state.
REQ-022 FSM states SHALL be IDLE, RUN, DONE.
REQ-023 IDLE: Start -> RUN with PC <= Start_pc; otherwise PC holds.
REQ-024 RUN, per-cycle priority SHALL be Halt > Stall > Branch > increment.
REQ-025 Halt in RUN -> DONE, PC holds, Done pulses next cycle.
REQ-026 Stall in RUN (no Halt): PC holds.
REQ-027 Branch, relative entry: PC <= PC + sign-extended value, modulo 2^PC_W.
REQ-028 Branch, absolute entry: PC <= value.
REQ-029 No Halt, Stall or Branch in RUN: PC <= PC + 1 modulo 2^PC_W.
REQ-030 Wrap SHALL assert only for relative or increment updates whose true sum lies outside 0..2^PC_W-1; absolute loads never wrap.
REQ-031 DONE: Start -> RUN with PC <= Start_pc; otherwise state and PC hold.
REQ-032 Start in RUN SHALL be ignored.
REQ-033 Branch, Stall and Halt SHALL be ignored in IDLE and DONE.

Reset
REQ-034 Reset_n low SHALL force state IDLE, PC=0, Running=0, Done=0, Wrap=0 immediately, including mid-run.
REQ-035 Reset SHALL initialise table contents per REQ-036/REQ-037.

Configuration
REQ-036 With PC_LUT_INIT_EN defined, reset SHALL load relative entries 0:0, 1:-11, 2:+7, 3:-18, 4:+11, 5:+2, 6:+15, all others 0 relative.
REQ-037 Without PC_LUT_INIT_EN, reset SHALL clear every entry to value 0, mode relative.

Verification
REQ-038 INIT_EN, Start with Start_pc=20, Branch Ptr=1 in first RUN cycle -> PC 20, then 9, then 10.
REQ-039 Write entry 5 = 0x40 absolute, Branch Ptr=5 -> PC=0x40 next cycle, Wrap=0.
REQ-040 PC=0xFF, no control inputs -> PC=0x00, Wrap=1 for one cycle.
REQ-041 Halt+Stall+Branch same cycle at PC=12 -> PC stays 12, state DONE, Done one-cycle pulse.
REQ-042 Write entry 3 = +4 while Branch Ptr=3, INIT_EN, PC=30 -> PC=12 (old -18); next Branch Ptr=3 -> PC=16.
REQ-043 Reset_n low mid-run at PC=0x37 -> PC=0, Running=0 before next Clk edge; table restored.
